rv_md_seq: RTL

//  Issue/writeback sequencer between the EX stage and the mul/div unit.
//  - Accepts one M-extension op from EX and drives the unit's rdy/alu/operand inputs, holding them stable.
//  - Stalls the front end while the op is in flight.
//  - Captures the result and writes it to the register file through a dedicated write port.

---
 rtl/rv_md_seq_if.sv | 68 ++++++
 rtl/rv_md_seq.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/rv_md_seq_if.sv
// Shared types plus the EX / mul-div unit / writeback bundle around the M-extension sequencer.
// The sequencer takes the master modport; the environment (EX, unit, regfile) takes the slave.
package rv_md_pkg;
   typedef logic [31:0] u32_t;

   typedef enum logic [4:0] {
      ALU_ADD    = 5'd0,
      ALU_SUB    = 5'd1,
      ALU_SLL    = 5'd2,
      ALU_SLT    = 5'd3,
      ALU_SLTU   = 5'd4,
      ALU_XOR    = 5'd5,
      ALU_SRL    = 5'd6,
      ALU_SRA    = 5'd7,
      ALU_OR     = 5'd8,
      ALU_AND    = 5'd9,
      ALU_MUL    = 5'd16,
      ALU_MULH   = 5'd17,
      ALU_MULHSU = 5'd18,
      ALU_MULHU  = 5'd19,
      ALU_DIV    = 5'd20,
      ALU_DIVU   = 5'd21,
      ALU_REM    = 5'd22,
      ALU_REMU   = 5'd23
   } alu_t;

   function automatic logic is_m_op(alu_t op);
      return op inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                        ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
   endfunction

   function automatic logic is_div_op(alu_t op);
      return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
   endfunction
endpackage

interface rv_md_if;
   // EX side
   logic                ex_valid;
   rv_md_pkg::alu_t     ex_alu;
   logic [4:0]          ex_rd;
   rv_md_pkg::u32_t     ex_rs1;
   rv_md_pkg::u32_t     ex_rs2;
   logic                flush;
   // mul/div unit side
   logic                md_rdy;
   rv_md_pkg::alu_t     md_alu;
   rv_md_pkg::u32_t     md_rrd1;
   rv_md_pkg::u32_t     md_rrd2;
   rv_md_pkg::u32_t     md_rwdat;
   logic                md_cmpl;
   // front end / register-file side
   logic                stall;
   logic                wb_we;
   logic [4:0]          wb_rd;
   rv_md_pkg::u32_t     wb_dat;
   logic                err;

   modport master (
      input  ex_valid, ex_alu, ex_rd, ex_rs1, ex_rs2, flush, md_rwdat, md_cmpl,
      output md_rdy, md_alu, md_rrd1, md_rrd2, stall, wb_we, wb_rd, wb_dat, err
   );

   modport slave (
      output ex_valid, ex_alu, ex_rd, ex_rs1, ex_rs2, flush, md_rwdat, md_cmpl,
      input  md_rdy, md_alu, md_rrd1, md_rrd2, stall, wb_we, wb_rd, wb_dat, err
   );
endinterface

// File: rtl/rv_md_seq.sv
// Issue/writeback sequencer between EX and the mul/div unit: issues one op, stalls the
// front end while it is in flight, and writes the captured result to the register file.
module rv_md_seq
   import rv_md_pkg::*;
#(
   parameter int unsigned TMO = 32
) (
   input  logic   clk,
   input  logic   reset,
   rv_md_if.master bus
);

   localparam int unsigned CW = $clog2(TMO + 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      MULW  = 3'd1,
      DIVW  = 3'd2,
      DIVR  = 3'd3,
      DRAIN = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          seen_q, seen_d;
   logic          md_rdy_q, md_rdy_d;
   alu_t          md_alu_q, md_alu_d;
   u32_t          rrd1_q, rrd1_d;
   u32_t          rrd2_q, rrd2_d;
   logic [4:0]    rd_q, rd_d;
   logic          stall_q, stall_d;
   logic          wb_we_q, wb_we_d;
   logic [4:0]    wb_rd_q, wb_rd_d;
   u32_t          wb_dat_q, wb_dat_d;
   logic          err_q, err_d;

   // Next-state and output decode
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      seen_d   = seen_q;
      md_rdy_d = 1'b0;
      md_alu_d = md_alu_q;
      rrd1_d   = rrd1_q;
      rrd2_d   = rrd2_q;
      rd_d     = rd_q;
      wb_we_d  = 1'b0;
      wb_rd_d  = wb_rd_q;
      wb_dat_d = wb_dat_q;
      err_d    = err_q;

      case (state_q)
         IDLE: begin
            if (bus.ex_valid && !bus.flush && is_m_op(bus.ex_alu)) begin
               md_alu_d = bus.ex_alu;
               rrd1_d   = bus.ex_rs1;
               rrd2_d   = bus.ex_rs2;
               rd_d     = bus.ex_rd;
               md_rdy_d = 1'b1;
               cnt_d    = '0;
               seen_d   = 1'b0;
               state_d  = is_div_op(bus.ex_alu) ? DIVW : MULW;
            end
         end
         MULW: begin
            state_d = IDLE;
            if (!bus.flush) begin
               wb_dat_d = bus.md_rwdat;
               wb_rd_d  = rd_q;
               wb_we_d  = (rd_q != 5'd0);
            end
         end
         DIVW: begin
            // flush beats a same-cycle completion; the drain then only needs its tail
            if (bus.flush) begin
               seen_d  = bus.md_cmpl;
               state_d = DRAIN;
            end else if (bus.md_cmpl) begin
               state_d = DIVR;
            end else if (cnt_q == CW'(TMO - 1)) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = CW'(cnt_q + 1'b1);
            end
         end
         DIVR: begin
            state_d = IDLE;
            if (!bus.flush) begin
               wb_dat_d = bus.md_rwdat;
               wb_rd_d  = rd_q;
               wb_we_d  = (rd_q != 5'd0);
            end
         end
         DRAIN: begin
            // wait out the abandoned divide so the unit is idle before the next issue
            if (seen_q) begin
               state_d = IDLE;
            end else if (bus.md_cmpl) begin
               seen_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      stall_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         seen_q   <= 1'b0;
         md_rdy_q <= 1'b0;
         md_alu_q <= ALU_ADD;
         rrd1_q   <= '0;
         rrd2_q   <= '0;
         rd_q     <= '0;
         stall_q  <= 1'b0;
         wb_we_q  <= 1'b0;
         wb_rd_q  <= '0;
         wb_dat_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         seen_q   <= seen_d;
         md_rdy_q <= md_rdy_d;
         md_alu_q <= md_alu_d;
         rrd1_q   <= rrd1_d;
         rrd2_q   <= rrd2_d;
         rd_q     <= rd_d;
         stall_q  <= stall_d;
         wb_we_q  <= wb_we_d;
         wb_rd_q  <= wb_rd_d;
         wb_dat_q <= wb_dat_d;
         err_q    <= err_d;
      end
   end

   assign bus.md_rdy  = md_rdy_q;
   assign bus.md_alu  = md_alu_q;
   assign bus.md_rrd1 = rrd1_q;
   assign bus.md_rrd2 = rrd2_q;
   assign bus.stall   = stall_q;
   assign bus.wb_we   = wb_we_q;
   assign bus.wb_rd   = wb_rd_q;
   assign bus.wb_dat  = wb_dat_q;
   assign bus.err     = err_q;

endmodule
